// File: rtl/hram_delay_cal.sv
// hram_delay_cal: sweeps the 4-bit PLL read-clock delay, records a pass map and programs the centre of the
// longest passing window. Optional manual override of the delay when HRAM_DELAY_CAL_MANUAL_EN is defined.
module hram_delay_cal #(
  parameter int          SETTLE_CYCLES = 64,
  parameter int          TEST_REPS     = 4,
  parameter int          TIMEOUT       = 1024,
  parameter logic [3:0]  DEFAULT_DELAY = 4'd8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        ok_o,
  output logic [3:0]  cal_delay_o,
  output logic [15:0] pass_map_o,
  output logic        test_req_o,
  input  logic        test_ack_i,
  input  logic        test_pass_i
`ifdef HRAM_DELAY_CAL_MANUAL_EN
  ,
  input  logic        manual_en_i,
  input  logic [3:0]  manual_delay_i
`endif
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_SETTLE, S_TEST, S_NEXT, S_SCAN, S_APPLY
  } state_e;

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic               ok_q;
  logic [3:0]         cal_delay_q;
  logic [15:0]        pass_map_q;
  logic               test_req_q;
  logic [3:0]         step_q;
  logic [SET_W-1:0]   settle_cnt_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [7:0]         reps_q;
  logic [3:0]         scan_idx_q;
  logic [3:0]         run_start_q;
  logic [4:0]         run_len_q;
  logic [3:0]         best_start_q;
  logic [4:0]         best_len_q;
`ifdef HRAM_DELAY_CAL_MANUAL_EN
  logic [3:0]         cal_saved_q;
`endif

  logic               scan_bit_s;
  logic [3:0]         cand_start_s;
  logic [4:0]         cand_len_s;
  logic [3:0]         run_start_d;
  logic [4:0]         run_len_d;
  logic [3:0]         best_start_d;
  logic [4:0]         best_len_d;
  logic [4:0]         centre_s;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign ok_o        = ok_q;
  assign cal_delay_o = cal_delay_q;
  assign pass_map_o  = pass_map_q;
  assign test_req_o  = test_req_q;

  // Window scan: extend or restart the current run, close it on a 0 bit or at bit 15.
  always_comb begin
    scan_bit_s   = pass_map_q[scan_idx_q];
    run_start_d  = run_start_q;
    run_len_d    = 5'd0;
    cand_start_s = run_start_q;
    cand_len_s   = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    if (scan_bit_s) begin
      run_len_d = run_len_q + 5'd1;
      if (run_len_q == 5'd0) begin
        run_start_d = scan_idx_q;
      end else begin
        run_start_d = run_start_q;
      end
      cand_start_s = run_start_d;
      cand_len_s   = run_len_d;
    end else begin
      run_len_d = 5'd0;
    end
    // Strictly longer only, so the lowest-index window keeps ties.
    if ((!scan_bit_s || (scan_idx_q == 4'd15)) && (cand_len_s > best_len_q)) begin
      best_start_d = cand_start_s;
      best_len_d   = cand_len_s;
    end else begin
      best_start_d = best_start_q;
      best_len_d   = best_len_q;
    end
  end

  // Lower centre of the best window for even lengths.
  assign centre_s = {1'b0, best_start_q} + ((best_len_q - 5'd1) >> 1);

  // Calibration sequencer with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ok_q         <= 1'b0;
      cal_delay_q  <= DEFAULT_DELAY;
      pass_map_q   <= 16'h0000;
      test_req_q   <= 1'b0;
      step_q       <= 4'd0;
      settle_cnt_q <= '0;
      tmo_q        <= '0;
      reps_q       <= 8'd0;
      scan_idx_q   <= 4'd0;
      run_start_q  <= 4'd0;
      run_len_q    <= 5'd0;
      best_start_q <= 4'd0;
      best_len_q   <= 5'd0;
`ifdef HRAM_DELAY_CAL_MANUAL_EN
      cal_saved_q  <= DEFAULT_DELAY;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
`ifdef HRAM_DELAY_CAL_MANUAL_EN
          if (manual_en_i) begin
            cal_delay_q <= manual_delay_i;
          end else begin
            cal_delay_q <= cal_saved_q;
            if (start_i) begin
              pass_map_q <= 16'h0000;
              ok_q       <= 1'b0;
              step_q     <= 4'd0;
              busy_q     <= 1'b1;
              state_q    <= S_SET;
            end
          end
`else
          if (start_i) begin
            pass_map_q <= 16'h0000;
            ok_q       <= 1'b0;
            step_q     <= 4'd0;
            busy_q     <= 1'b1;
            state_q    <= S_SET;
          end
`endif
        end
        S_SET: begin
          cal_delay_q  <= step_q;
          settle_cnt_q <= SET_W'(SETTLE_CYCLES);
          state_q      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt_q == '0) begin
            test_req_q <= 1'b1;
            reps_q     <= 8'd0;
            tmo_q      <= '0;
            state_q    <= S_TEST;
          end else begin
            settle_cnt_q <= settle_cnt_q - SET_W'(1);
          end
        end
        S_TEST: begin
          if (test_req_q) begin
            if (test_ack_i) begin
              test_req_q <= 1'b0;
              tmo_q      <= '0;
              if (!test_pass_i) begin
                state_q <= S_NEXT;
              end else if ((reps_q + 8'd1) >= 8'(TEST_REPS)) begin
                pass_map_q[step_q] <= 1'b1;
                state_q            <= S_NEXT;
              end else begin
                reps_q <= reps_q + 8'd1;
              end
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
              test_req_q <= 1'b0;
              state_q    <= S_NEXT;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end else begin
            // Re-request one cycle after a passing ack.
            test_req_q <= 1'b1;
            tmo_q      <= '0;
          end
        end
        S_NEXT: begin
          if (step_q == 4'd15) begin
            scan_idx_q   <= 4'd0;
            run_start_q  <= 4'd0;
            run_len_q    <= 5'd0;
            best_start_q <= 4'd0;
            best_len_q   <= 5'd0;
            state_q      <= S_SCAN;
          end else begin
            step_q  <= step_q + 4'd1;
            state_q <= S_SET;
          end
        end
        S_SCAN: begin
          run_start_q  <= run_start_d;
          run_len_q    <= run_len_d;
          best_start_q <= best_start_d;
          best_len_q   <= best_len_d;
          if (scan_idx_q == 4'd15) begin
            state_q <= S_APPLY;
          end else begin
            scan_idx_q <= scan_idx_q + 4'd1;
          end
        end
        S_APPLY: begin
          if (best_len_q != 5'd0) begin
            cal_delay_q <= centre_s[3:0];
            ok_q        <= 1'b1;
`ifdef HRAM_DELAY_CAL_MANUAL_EN
            cal_saved_q <= centre_s[3:0];
`endif
          end else begin
            cal_delay_q <= DEFAULT_DELAY;
            ok_q        <= 1'b0;
`ifdef HRAM_DELAY_CAL_MANUAL_EN
            cal_saved_q <= DEFAULT_DELAY;
`endif
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hram_delay_cal.sv
// Directed bench for hram_delay_cal: a cycle-stepped tester model answers test_req from a pass mask
// and results are compared against hand-computed values.
module tb_hram_delay_cal;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic        ok_o;
  logic [3:0]  cal_delay_o;
  logic [15:0] pass_map_o;
  logic        test_req_o;
  logic        test_ack_i;
  logic        test_pass_i;
`ifdef HRAM_DELAY_CAL_MANUAL_EN
  logic        manual_en_i;
  logic [3:0]  manual_delay_i;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic       prev_req;
  logic [3:0] prev_cal;
  logic       seen3;
  int         wait_cnt;
  int         reqs;
  int         done_pulses;
  int         rise_cyc;
  int         tmo_len;
  int         chg3_cyc;
  int         settle_gap;

  hram_delay_cal dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .ok_o           (ok_o),
    .cal_delay_o    (cal_delay_o),
    .pass_map_o     (pass_map_o),
    .test_req_o     (test_req_o),
    .test_ack_i     (test_ack_i),
    .test_pass_i    (test_pass_i)
`ifdef HRAM_DELAY_CAL_MANUAL_EN
    ,
    .manual_en_i    (manual_en_i),
    .manual_delay_i (manual_delay_i)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle of the external tester: acks two cycles into each request, result from mask[cal_delay].
  task automatic tester(input logic [15:0] mask, input int noack);
    @(negedge clk);
    test_ack_i = 1'b0;
    start_i    = 1'b0;
    if (done_o) done_pulses++;
    if (busy_o && cal_delay_o == 4'd3 && prev_cal != 4'd3 && !seen3) begin
      chg3_cyc = cyc;
      seen3    = 1'b1;
    end
    if (test_req_o && !prev_req) begin
      reqs++;
      if (cal_delay_o == 4'd3 && settle_gap < 0) settle_gap = cyc - chg3_cyc;
      if (int'(cal_delay_o) == noack) rise_cyc = cyc;
    end
    if (!test_req_o && prev_req && int'(cal_delay_o) == noack) tmo_len = cyc - rise_cyc;
    prev_req = test_req_o;
    prev_cal = cal_delay_o;
    if (test_req_o && int'(cal_delay_o) != noack) begin
      wait_cnt++;
      if (wait_cnt == 2) begin
        test_ack_i  = 1'b1;
        test_pass_i = mask[cal_delay_o];
        wait_cnt    = 0;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  task automatic clear_tester();
    prev_req    = test_req_o;
    prev_cal    = cal_delay_o;
    seen3       = 1'b0;
    wait_cnt    = 0;
    reqs        = 0;
    done_pulses = 0;
    rise_cyc    = 0;
    tmo_len     = -1;
    chg3_cyc    = 0;
    settle_gap  = -1;
  endtask

  // Full calibration with a bounded cycle budget; runs three extra cycles after done.
  task automatic run_cal(input logic [15:0] mask, input int noack);
    int n;
    int after;
    clear_tester();
    @(negedge clk);
    start_i = 1'b1;
    n     = 0;
    after = -1;
    while (n < 20000 && after != 0) begin
      tester(mask, noack);
      n++;
      if (after > 0) after--;
      else if (after < 0 && done_pulses > 0) after = 3;
    end
  endtask

  initial begin
    int  n;
    logic hit;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    test_ack_i  = 1'b0;
    test_pass_i = 1'b0;
`ifdef HRAM_DELAY_CAL_MANUAL_EN
    manual_en_i    = 1'b0;
    manual_delay_i = 4'd0;
`endif
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_ok", 32'(ok_o), 32'd0);
    check("rst_req", 32'(test_req_o), 32'd0);
    check("rst_map", 32'(pass_map_o), 32'h0000);
    check("rst_delay", 32'(cal_delay_o), 32'd8);

    // Window 5..10 -> centre 7; also the settle-to-request gap at delay 3.
    run_cal(16'h07E0, -1);
    check("w510_map", 32'(pass_map_o), 32'h07E0);
    check("w510_delay", 32'(cal_delay_o), 32'd7);
    check("w510_ok", 32'(ok_o), 32'd1);
    check("w510_done_pulses", 32'(done_pulses), 32'd1);
    check("w510_busy", 32'(busy_o), 32'd0);
    check("settle_gap", 32'(settle_gap), 32'd65);

    // Two 3-wide windows: lowest wins.
    run_cal(16'h0E1C, -1);
    check("tie_map", 32'(pass_map_o), 32'h0E1C);
    check("tie_delay", 32'(cal_delay_o), 32'd3);
    check("tie_ok", 32'(ok_o), 32'd1);

    // Everything fails: one request per step, default delay.
    run_cal(16'h0000, -1);
    check("fail_map", 32'(pass_map_o), 32'h0000);
    check("fail_ok", 32'(ok_o), 32'd0);
    check("fail_delay", 32'(cal_delay_o), 32'd8);
    check("fail_reqs", 32'(reqs), 32'd16);
    check("fail_done_pulses", 32'(done_pulses), 32'd1);

    // No ack at delay 6: timeout then window 7..15.
    run_cal(16'hFFFF, 6);
    check("tmo_len", 32'(tmo_len), 32'd1024);
    check("tmo_map", 32'(pass_map_o), 32'hFFBF);
    check("tmo_delay", 32'(cal_delay_o), 32'd11);
    check("tmo_ok", 32'(ok_o), 32'd1);

    // Start mid-sweep is ignored; reset at step 9 aborts.
    clear_tester();
    @(negedge clk);
    start_i = 1'b1;
    n   = 0;
    hit = 1'b0;
    while (n < 5000 && !hit) begin
      tester(16'hFFFF, -1);
      if (n == 200) start_i = 1'b1;
      n++;
      if (cal_delay_o == 4'd9 && test_req_o) hit = 1'b1;
    end
    check("abort_reached_step9", 32'(hit), 32'd1);
    check("abort_map_before", 32'(pass_map_o), 32'h01FF);
    check("abort_busy_before", 32'(busy_o), 32'd1);
    test_ack_i = 1'b0;
    start_i    = 1'b0;
    rst_i      = 1'b1;
    @(negedge clk);
    check("abort_delay", 32'(cal_delay_o), 32'd8);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_req", 32'(test_req_o), 32'd0);
    check("abort_map", 32'(pass_map_o), 32'h0000);
    check("abort_ok", 32'(ok_o), 32'd0);
    rst_i       = 1'b0;
    test_ack_i  = 1'b1;
    test_pass_i = 1'b1;
    @(negedge clk);
    test_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    check("late_ack_map", 32'(pass_map_o), 32'h0000);
    check("late_ack_busy", 32'(busy_o), 32'd0);
    check("late_ack_req", 32'(test_req_o), 32'd0);
    check("late_ack_delay", 32'(cal_delay_o), 32'd8);
    check("late_ack_done", 32'(done_o), 32'd0);

`ifdef HRAM_DELAY_CAL_MANUAL_EN
    manual_delay_i = 4'd12;
    manual_en_i    = 1'b1;
    @(negedge clk);
    check("manual_delay", 32'(cal_delay_o), 32'd12);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("manual_start_ignored", 32'(busy_o), 32'd0);
    manual_en_i = 1'b0;
    @(negedge clk);
    check("manual_restore", 32'(cal_delay_o), 32'd8);
`else
    repeat (4) @(negedge clk);
    check("idle_delay_stable", 32'(cal_delay_o), 32'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
